// File: rtl/dm_access_master_pkg.sv
// +--------------------------------------------------------------------------+
// | dm_access_pkg: op encodings, FSM states and helpers for dm_access_master |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package dm_access_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic is_store(input logic [2:0] op);
    return op >= OP_SW;
  endfunction

  // Byte offset actually used by the lane logic: word ops ignore [1:0], half ops ignore [0].
  function automatic logic [1:0] eff_offset(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return 2'b00;
      OP_LH, OP_LHU, OP_SH: return {a[1], 1'b0};
      default:              return a;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return a != 2'b00;
      OP_LH, OP_LHU, OP_SH: return a[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_access_master_if.sv
// +--------------------------------------------------------------------------+
// | dm_access_master_if: pipeline request/response and word-only DM bus      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface dm_access_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0] req_pc;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_pc;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_re, mem_we, mem_addr, mem_wdata, mem_pc
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_re, mem_we, mem_addr, mem_wdata, mem_pc
  );
endinterface

`default_nettype wire

// File: rtl/dm_access_master_lane_merge.sv
// +--------------------------------------------------------------------------+
// | dm_lane_merge: sub-word load extension and store lane merge (comb.)      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module dm_lane_merge
  import dm_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];

    load_val = word;
    case (op)
      OP_LH:   load_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {{(DATA_W-16){1'b0}}, half_sel};
      OP_LB:   load_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {{(DATA_W-8){1'b0}}, byte_sel};
      default: load_val = word;
    endcase

    store_word = wdata;
    case (op)
      OP_SH: begin
        store_word = word;
        store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      OP_SB: begin
        store_word = word;
        store_word[{off, 3'b000} +: 8] = wdata[7:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_access_master.sv
// +--------------------------------------------------------------------------+
// | dm_access_master: MEM-stage initiator on a word-only DM port; sub-word   |
// | loads are extended, SB/SH become read-modify-write.                      |
// | Optional: ALIGN_EXC_EN reports misaligned accesses via rsp_err.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module dm_access_master
  import dm_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  dm_access_master_if.master  bus
);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef ALIGN_EXC_EN
  logic              err_q, err_d;
`endif

  logic              accept;
  logic              misalign;
  logic [DATA_W-1:0] lane_word;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] store_word;

  // LOAD extracts straight from the DM word; WRITE merges into the buffered word.
  assign lane_word = (state_q == S_LOAD) ? bus.mem_rdata : buf_q;

  dm_lane_merge #(.DATA_W(DATA_W)) u_lane (
    .op         (op_q),
    .off        (eff_offset(op_q, addr_q[1:0])),
    .word       (lane_word),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
    accept   = bus.req_valid && (state_q == S_IDLE);
`ifdef ALIGN_EXC_EN
    err_d    = err_q;
    misalign = is_misaligned(bus.req_op, bus.req_addr[1:0]);
`else
    misalign = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          pc_d    = bus.req_pc;
`ifdef ALIGN_EXC_EN
          err_d   = misalign;
`endif
          if (misalign)                 state_d = S_DONE;
          else if (bus.req_op == OP_SW) state_d = S_WRITE;
          else if (is_store(bus.req_op)) state_d = S_RMW_RD;
          else                          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rdata_d = load_val;
        state_d = S_DONE;
      end
      S_RMW_RD: begin
        buf_d   = bus.mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
`ifdef ALIGN_EXC_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
`ifdef ALIGN_EXC_EN
      err_q   <= err_d;
`endif
    end
  end

  // Strobes are qualified by reset so an op caught mid-flight never touches DM.
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_re    = reset && ((state_q == S_LOAD) || (state_q == S_RMW_RD));
  assign bus.mem_we    = reset && (state_q == S_WRITE);
  assign bus.mem_addr  = (state_q == S_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_pc    = (state_q == S_IDLE) ? '0 : pc_q;
  assign bus.mem_wdata = (state_q == S_WRITE) ? store_word : '0;
`ifdef ALIGN_EXC_EN
  assign bus.rsp_err   = err_q && (state_q == S_DONE);
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_access_master.sv
// +--------------------------------------------------------------------------+
// | tb_dm_access_master: directed vectors with a response/write scoreboard   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dm_access_master;

  typedef struct {
    logic [31:0] rdata;
    logic        chk;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rd_cnt = 0;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t m_rsp;
  wr_t  m_wr;

  logic [31:0] mem [0:63];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;

  dm_access_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dm_access_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected responses/writes whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_re) rd_cnt++;
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp_valid", 32'd1, 32'd0);
        end else begin
          m_rsp = rsp_q.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(m_rsp.cyc));
          check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_rsp.err});
          if (m_rsp.chk) check("rsp_rdata", bus.rsp_rdata, m_rsp.rdata);
        end
      end
      if (bus.mem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_mem_we", 32'd1, 32'd0);
        end else begin
          m_wr = wr_q.pop_front();
          check("wr_cycle", 32'(cyc), 32'(m_wr.cyc));
          check("wr_addr", bus.mem_addr, m_wr.addr);
          check("wr_data", bus.mem_wdata, m_wr.data);
          check("wr_pc", bus.mem_pc, m_wr.pc);
        end
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = 6'(idx);
    poke_val = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Issues one request; expectations are pushed at accept time when push=1.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic push, input int lat,
                       input logic chk, input logic [31:0] exp_rd, input logic exp_err,
                       input logic has_wr, input int wr_lat, input logic [31:0] wr_data);
    int guard;
    rsp_t r;
    wr_t  w;
    @(negedge clk);
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_pc    = pc;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'd0, 32'd1);
    if (push) begin
      r.rdata = exp_rd; r.chk = chk; r.err = exp_err; r.cyc = cyc + lat;
      rsp_q.push_back(r);
      if (has_wr) begin
        w.addr = {addr[31:2], 2'b00}; w.data = wr_data; w.pc = pc; w.cyc = cyc + wr_lat;
        wr_q.push_back(w);
      end
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain_rsp_left", 32'(rsp_q.size()), 32'd0);
    check("drain_wr_left", 32'(wr_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_before;
    rst_n         = 1'b0;
    poke_en       = 1'b0;
    poke_idx      = '0;
    poke_val      = '0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_pc    = '0;
    for (int i = 0; i < 64; i++) poke(i, 32'd0);

    @(negedge clk);
    check("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("reset_mem_re", {31'd0, bus.mem_re}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_mem_pc", bus.mem_pc, 32'd0);

    // SW then LW round trip
    issue(3'd5, 32'h10, 32'h12345678, 32'h100, 1, 2, 0, 32'h0, 0, 1, 1, 32'h12345678);
    issue(3'd0, 32'h10, 32'h0,        32'h104, 1, 2, 1, 32'h12345678, 0, 0, 0, 32'h0);
    drain();

    // SB into the middle of an existing word
    rd_before = rd_cnt;
    issue(3'd7, 32'h11, 32'h000000AB, 32'h108, 1, 3, 0, 32'h0, 0, 1, 2, 32'h1234AB78);
    drain();
    check("sb_read_count", 32'(rd_cnt - rd_before), 32'd1);
    check("sb_mem_word", mem[4], 32'h1234AB78);

    // Sub-word load extension
    poke(0, 32'h80FF7F01);
    issue(3'd3, 32'h3, 32'h0, 32'h200, 1, 2, 1, 32'hFFFFFF80, 0, 0, 0, 32'h0);
    issue(3'd4, 32'h3, 32'h0, 32'h204, 1, 2, 1, 32'h00000080, 0, 0, 0, 32'h0);
    issue(3'd1, 32'h0, 32'h0, 32'h208, 1, 2, 1, 32'h00007F01, 0, 0, 0, 32'h0);
    issue(3'd2, 32'h2, 32'h0, 32'h20C, 1, 2, 1, 32'h000080FF, 0, 0, 0, 32'h0);
    issue(3'd1, 32'h2, 32'h0, 32'h210, 1, 2, 1, 32'hFFFF80FF, 0, 0, 0, 32'h0);
    issue(3'd3, 32'h1, 32'h0, 32'h214, 1, 2, 1, 32'h0000007F, 0, 0, 0, 32'h0);
    drain();

    // SH into upper half; req_ready low for three cycles after accept
    issue(3'd6, 32'h22, 32'h0000BEEF, 32'h300, 1, 3, 0, 32'h0, 0, 1, 2, 32'hBEEF0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sh_ready_busy", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    check("sh_ready_back", {31'd0, bus.req_ready}, 32'd1);
    drain();
    check("sh_mem_word", mem[8], 32'hBEEF0000);

    // Reset lands in the WRITE cycle of an SB
    issue(3'd7, 32'h12, 32'h000000CD, 32'h400, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_write_mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_write_idle", {31'd0, bus.req_ready}, 32'd1);
    check("rst_write_rdata", bus.rsp_rdata, 32'd0);
    repeat (4) @(negedge clk);
    check("rst_write_mem_word", mem[4], 32'h1234AB78);
    check("rst_write_no_rsp", 32'(rsp_q.size()), 32'd0);

    // Misaligned LW
    rd_before = rd_cnt;
`ifdef ALIGN_EXC_EN
    issue(3'd0, 32'h13, 32'h0, 32'h500, 1, 1, 1, 32'h00000000, 1, 0, 0, 32'h0);
    drain();
    check("misalign_reads", 32'(rd_cnt - rd_before), 32'd0);
`else
    issue(3'd0, 32'h13, 32'h0, 32'h500, 1, 2, 1, 32'h1234AB78, 0, 0, 0, 32'h0);
    drain();
    check("misalign_reads", 32'(rd_cnt - rd_before), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
